uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter with configurable data width, parity and stop-bit count, and a one-word holding register that allows back-to-back frames with no idle gap. It sits between the byte-producing logic and the serial TX pin, at the same level as the existing 8N1 transmitter. Input uses a ready/valid handshake, so upstream can queue the next word while the current frame is still shifting.

## Interface

- CLKS_PER_BIT, 217, clock cycles per serial bit (≥2)
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)

- i_Clk  input  1  clock; all logic on the rising edge
- i_Rst_n  input  1  asynchronous active-low reset
- i_TX_DV  input  1  word valid; accepted on an edge where i_TX_DV && o_TX_Ready
- i_TX_Byte  input  DATA_BITS  word to send, LSB first
- o_TX_Ready  output  1  holding register empty; word can be accepted
- o_TX_Active  output  1  frame in progress
- o_TX_Serial  output  1  serial line; idle high
- o_TX_Done  output  1  one-cycle pulse at the end of each frame

## Operation

- Reset (asynchronous, immediate): o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, state IDLE, counters 0, holding register invalid. A reset in mid-frame aborts the frame, drives the line high and discards any held word.
- Frame format: start (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Parity bit: XOR of the data bits (even mode); inverted XOR (odd mode).
- States: IDLE → START → DATA → [PARITY if PARITY_MODE≠0] → STOP → IDLE or START.
- Every state lasts exactly CLKS_PER_BIT cycles. The bit counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
- DATA advances its bit index 0..DATA_BITS-1. STOP repeats for STOP_BITS bit periods.
- The holding register is one word deep. o_TX_Ready = !hold_valid.
- In IDLE, an accepted word bypasses the holding register and loads the shift register directly.
- While a frame is active, an accepted word goes to the holding register.
- At the final edge of the last stop bit:
  - hold valid → move it to the shift register, clear hold, enter START (zero-gap back-to-back).
  - hold empty → enter IDLE.
- o_TX_Serial is registered and driven from the state and shift register. It is never low in IDLE.
- The idle line is 1. A non-zero baud divisor is guaranteed by the parameter check: CLKS_PER_BIT<2, DATA_BITS outside 5..9, PARITY_MODE>2 or STOP_BITS∉{1,2} is an elaboration error.

## Timing

- Accept in IDLE at edge N: o_TX_Serial=0 and o_TX_Active=1 from edge N. o_TX_Ready stays 1.
- Frame length: F = CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS) cycles, where P=1 if parity is enabled.
- The end-of-frame edge is N+F:
  - o_TX_Done=1 for exactly the cycle after that edge.
  - With no held word, o_TX_Active=0 from that edge on.
  - With a held word, o_TX_Active stays 1, o_TX_Serial=0 (next start bit) and o_TX_Ready=1 from that edge on.
- Word accepted while hold is empty and a frame is active: o_TX_Ready=0 from the next edge until the end-of-frame edge.
- Simultaneous accept and end-of-frame:
  - If hold was valid, Ready is 0, so no accept can occur.
  - If hold was empty and i_TX_DV=1 at the end-of-frame edge, the word is taken straight into the shift register and a new START begins with no gap.
- i_TX_DV while o_TX_Ready=0 is ignored; the word is not stored and the in-flight frame is unaffected.
- Sustained throughput: one word per F cycles, with no idle bits between frames.

## Test plan

- 8N1, CLKS_PER_BIT=4, send 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Done pulses once at cycle 40. Active is high for cycles 0..39. Line is 1 afterwards.
- 8E1 and 8O1 with 0xA5 → parity bit 0 (even) or 1 (odd), frame 44 cycles. With 0x07: even gives 1, odd gives 0.
- 7N2, CLKS_PER_BIT=3: send 0x41 → 7 data bits 1,0,0,0,0,0,1, then stop held for 6 cycles. Frame is 30 cycles.
- Back-to-back: send 0x55, then 0xAA four cycles later → Ready is 0 until the first end-of-frame edge. The second start bit immediately follows the first stop bit. Done pulses twice, F cycles apart. Active never drops between frames.
- Hold full: with hold valid, assert i_TX_DV with 0xFF → the word is ignored, and only the two queued frames appear on the line.
- Reset mid-frame: deassert i_Rst_n during data bit 3 → Serial=1, Active=0, Done=0 and Ready=1 immediately, without waiting for a clock edge. After release, a new 0x3C frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS data bits LSB first, optional parity, STOP_BITS stops.
// A one-word holding register lets the next frame start with no idle gap.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_frame: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_clk_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_valid;
  logic                 r_parity;
  logic                 r_serial;
  logic                 r_active;
  logic                 r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_frame_end;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY_MODE == 1);
  endfunction

  assign w_accept    = i_TX_DV && !r_hold_valid;
  assign w_bit_end   = (r_clk_cnt == CNT_MAX);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_idx == LAST_STOP);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state      <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_parity     <= 1'b0;
      r_serial     <= 1'b1;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_clk_cnt <= '0;
        r_bit_idx <= '0;
        if (w_accept) begin
          r_shift  <= i_TX_Byte;
          r_parity <= parity_of(i_TX_Byte);
          r_state  <= S_START;
          r_serial <= 1'b0;
          r_active <= 1'b1;
        end
      end else begin
        // At the end-of-frame edge an accepted word goes straight to the shifter.
        if (w_accept && !w_frame_end) begin
          r_hold       <= i_TX_Byte;
          r_hold_valid <= 1'b1;
        end
        if (!w_bit_end) begin
          r_clk_cnt <= r_clk_cnt + 1'b1;
        end else begin
          r_clk_cnt <= '0;
          case (r_state)
            S_START: begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
              r_serial  <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
            S_DATA: begin
              if (r_bit_idx == LAST_BIT) begin
                r_bit_idx <= '0;
                if (PARITY_MODE != 0) begin
                  r_state  <= S_PARITY;
                  r_serial <= r_parity;
                end else begin
                  r_state  <= S_STOP;
                  r_serial <= 1'b1;
                end
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_serial  <= r_shift[0];
                r_shift   <= r_shift >> 1;
              end
            end
            S_PARITY: begin
              r_state   <= S_STOP;
              r_bit_idx <= '0;
              r_serial  <= 1'b1;
            end
            S_STOP: begin
              if (r_bit_idx != LAST_STOP) begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end else begin
                r_done    <= 1'b1;
                r_bit_idx <= '0;
                if (r_hold_valid) begin
                  r_shift      <= r_hold;
                  r_parity     <= parity_of(r_hold);
                  r_hold_valid <= 1'b0;
                  r_state      <= S_START;
                  r_serial     <= 1'b0;
                end else if (i_TX_DV) begin
                  r_shift  <= i_TX_Byte;
                  r_parity <= parity_of(i_TX_Byte);
                  r_state  <= S_START;
                  r_serial <= 1'b0;
                end else begin
                  r_state  <= S_IDLE;
                  r_serial <= 1'b1;
                  r_active <= 1'b0;
                end
              end
            end
            default: begin
              r_state  <= S_IDLE;
              r_serial <= 1'b1;
              r_active <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign o_TX_Ready  = !r_hold_valid;
  assign o_TX_Active = r_active;
  assign o_TX_Serial = r_serial;
  assign o_TX_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1 at 4 clk/bit, 7N2 at 3 clk/bit)
// checked cycle by cycle against a frame model built from the bit-level frame rules.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       dv  [4];
  logic [7:0] wb  [4];
  logic       rdy [4];
  logic       act [4];
  logic       ser [4];
  logic       dn  [4];

  int total = 0;
  int bad   = 0;

  int cpb_t [4] = '{4, 4, 4, 3};
  int db_t  [4] = '{8, 8, 8, 7};
  int pm_t  [4] = '{0, 2, 1, 0};
  int sb_t  [4] = '{1, 1, 1, 2};

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[0]), .i_TX_Byte(wb[0]),
    .o_TX_Ready(rdy[0]), .o_TX_Active(act[0]), .o_TX_Serial(ser[0]), .o_TX_Done(dn[0]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[1]), .i_TX_Byte(wb[1]),
    .o_TX_Ready(rdy[1]), .o_TX_Active(act[1]), .o_TX_Serial(ser[1]), .o_TX_Done(dn[1]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[2]), .i_TX_Byte(wb[2]),
    .o_TX_Ready(rdy[2]), .o_TX_Active(act[2]), .o_TX_Serial(ser[2]), .o_TX_Done(dn[2]));
  uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[3]), .i_TX_Byte(wb[3][6:0]),
    .o_TX_Ready(rdy[3]), .o_TX_Active(act[3]), .o_TX_Serial(ser[3]), .o_TX_Done(dn[3]));

  // Serial bit i of the frame is bit i of the result; unused high bits read as idle 1.
  function automatic logic [15:0] frame_bits(input int idx, input logic [7:0] w);
    logic [15:0] f;
    int n;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    n    = 1;
    ones = 0;
    for (int i = 0; i < db_t[idx]; i++) begin
      f[n] = w[i];
      ones += int'(w[i]);
      n++;
    end
    if (pm_t[idx] == 2) f[n] = (ones % 2) == 1;
    if (pm_t[idx] == 1) f[n] = (ones % 2) == 0;
    return f;
  endfunction

  function automatic int frame_cycles(input int idx);
    return cpb_t[idx] * (1 + db_t[idx] + ((pm_t[idx] != 0) ? 1 : 0) + sb_t[idx]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dv[i] = 1'b0;
      wb[i] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (ser[i] !== 1'b1) begin bad++; $display("FAIL reset_serial dut=%0d got=%b exp=1", i, ser[i]); end
      total++; if (act[i] !== 1'b0) begin bad++; $display("FAIL reset_active dut=%0d got=%b exp=0", i, act[i]); end
      total++; if (dn[i]  !== 1'b0) begin bad++; $display("FAIL reset_done dut=%0d got=%b exp=0", i, dn[i]); end
      total++; if (rdy[i] !== 1'b1) begin bad++; $display("FAIL reset_ready dut=%0d got=%b exp=1", i, rdy[i]); end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Single frame from idle: line, active, done and ready checked every cycle.
  task automatic test_frame(input int idx, input logic [7:0] w, input string name);
    logic [15:0] f;
    int          fc;
    logic        e_ser;
    f  = frame_bits(idx, w);
    fc = frame_cycles(idx);
    @(negedge clk);
    dv[idx] = 1'b1;
    wb[idx] = w;
    @(posedge clk);
    #1 dv[idx] = 1'b0;
    for (int k = 0; k <= fc + 1; k++) begin
      @(negedge clk);
      e_ser = (k < fc) ? f[k / cpb_t[idx]] : 1'b1;
      total++; if (ser[idx] !== e_ser) begin bad++; $display("FAIL %s serial k=%0d got=%b exp=%b", name, k, ser[idx], e_ser); end
      total++; if (act[idx] !== (k < fc)) begin bad++; $display("FAIL %s active k=%0d got=%b exp=%b", name, k, act[idx], k < fc); end
      total++; if (dn[idx] !== (k == fc)) begin bad++; $display("FAIL %s done k=%0d got=%b exp=%b", name, k, dn[idx], k == fc); end
      total++; if (rdy[idx] !== 1'b1) begin bad++; $display("FAIL %s ready k=%0d got=%b exp=1", name, k, rdy[idx]); end
    end
  endtask

  // 0x55 then 0xAA queued four cycles in; 0xFF offered while the hold is full must vanish.
  task automatic test_back_to_back();
    logic [15:0] f1, f2;
    int          fc, c;
    logic        e_ser, e_rdy;
    f1 = frame_bits(0, 8'h55);
    f2 = frame_bits(0, 8'hAA);
    fc = frame_cycles(0);
    c  = cpb_t[0];
    @(negedge clk);
    dv[0] = 1'b1;
    wb[0] = 8'h55;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    for (int k = 0; k <= 2 * fc + 1; k++) begin
      @(negedge clk);
      e_ser = (k < fc) ? f1[k / c] : (k < 2 * fc) ? f2[(k - fc) / c] : 1'b1;
      e_rdy = !(k >= 4 && k < fc);
      total++; if (ser[0] !== e_ser) begin bad++; $display("FAIL b2b serial k=%0d got=%b exp=%b", k, ser[0], e_ser); end
      total++; if (act[0] !== (k < 2 * fc)) begin bad++; $display("FAIL b2b active k=%0d got=%b exp=%b", k, act[0], k < 2 * fc); end
      total++; if (dn[0] !== (k == fc || k == 2 * fc)) begin bad++; $display("FAIL b2b done k=%0d got=%b exp=%b", k, dn[0], k == fc || k == 2 * fc); end
      total++; if (rdy[0] !== e_rdy) begin bad++; $display("FAIL b2b ready k=%0d got=%b exp=%b", k, rdy[0], e_rdy); end
      dv[0] = (k == 3) || (k >= 10 && k <= 13);
      wb[0] = (k == 3) ? 8'hAA : 8'hFF;
    end
    dv[0] = 1'b0;
  endtask

  // Second word offered exactly on the end-of-frame edge with the hold empty.
  task automatic test_eof_accept(input int idx);
    logic [15:0] f1, f2;
    logic [7:0]  w1, w2;
    int          fc, c;
    logic        e_ser;
    w1 = 8'($urandom_range(0, (1 << db_t[idx]) - 1));
    w2 = 8'($urandom_range(0, (1 << db_t[idx]) - 1));
    f1 = frame_bits(idx, w1);
    f2 = frame_bits(idx, w2);
    fc = frame_cycles(idx);
    c  = cpb_t[idx];
    @(negedge clk);
    dv[idx] = 1'b1;
    wb[idx] = w1;
    @(posedge clk);
    #1 dv[idx] = 1'b0;
    for (int k = 0; k <= 2 * fc + 1; k++) begin
      @(negedge clk);
      e_ser = (k < fc) ? f1[k / c] : (k < 2 * fc) ? f2[(k - fc) / c] : 1'b1;
      total++; if (ser[idx] !== e_ser) begin bad++; $display("FAIL eof_accept serial k=%0d got=%b exp=%b", k, ser[idx], e_ser); end
      total++; if (act[idx] !== (k < 2 * fc)) begin bad++; $display("FAIL eof_accept active k=%0d got=%b exp=%b", k, act[idx], k < 2 * fc); end
      total++; if (dn[idx] !== (k == fc || k == 2 * fc)) begin bad++; $display("FAIL eof_accept done k=%0d got=%b exp=%b", k, dn[idx], k == fc || k == 2 * fc); end
      total++; if (rdy[idx] !== 1'b1) begin bad++; $display("FAIL eof_accept ready k=%0d got=%b exp=1", k, rdy[idx]); end
      dv[idx] = (k == fc - 1);
      wb[idx] = w2;
    end
    dv[idx] = 1'b0;
  endtask

  // Reset during data bit 3 with a word held; outputs must change before any clock edge.
  task automatic test_reset_mid_frame();
    @(negedge clk);
    dv[0] = 1'b1;
    wb[0] = 8'h96;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    @(negedge clk);
    dv[0] = 1'b1;
    wb[0] = 8'h69;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL midrst held_ready got=%b exp=0", rdy[0]); end
    repeat (16) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (ser[0] !== 1'b1) begin bad++; $display("FAIL midrst serial got=%b exp=1", ser[0]); end
    total++; if (act[0] !== 1'b0) begin bad++; $display("FAIL midrst active got=%b exp=0", act[0]); end
    total++; if (dn[0]  !== 1'b0) begin bad++; $display("FAIL midrst done got=%b exp=0", dn[0]); end
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL midrst ready got=%b exp=1", rdy[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (act[0] !== 1'b0 || ser[0] !== 1'b1) begin
        bad++; $display("FAIL midrst idle_after k=%0d active=%b serial=%b exp=0/1", k, act[0], ser[0]);
      end
    end
    test_frame(0, 8'h3C, "after_reset_3c");
  endtask

  initial begin
    test_reset();
    test_frame(0, 8'hA5, "8n1_a5");
    test_frame(1, 8'hA5, "8e1_a5");
    test_frame(2, 8'hA5, "8o1_a5");
    test_frame(1, 8'h07, "8e1_07");
    test_frame(2, 8'h07, "8o1_07");
    test_frame(3, 8'h41, "7n2_41");
    test_back_to_back();
    test_eof_accept(3);
    test_eof_accept(1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        test_frame(i, 8'($urandom_range(0, (1 << db_t[i]) - 1)), "random");
      end
    end
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
